// File: rtl/dmem_arbiter_pkg.sv
// Shared size codes, FSM encodings and store-lane helper for the data-memory arbiter.
package dmem_arbiter_pkg;
  localparam int REG_SIZE   = 32;
  localparam int DMEM_ABITS = 12;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [1:0] {
    DA_IDLE  = 2'd0,
    DA_ISSUE = 2'd1,
    DA_WAIT  = 2'd2,
    DA_RESP  = 2'd3
  } da_state_e;

  // dmem picks the active lane from daddr, so narrow stores are copied to every lane.
  function automatic logic [REG_SIZE-1:0] lane_replicate(input logic [1:0] size,
                                                         input logic [REG_SIZE-1:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant with a registered last-grant pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);
  logic last_q;

  // On a tie the port that was not granted last time wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i && (|req_i)) begin
      last_q <= gnt_o[1];
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer in front of the byte-banked dmem.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DMEM_LAT = 2,
  parameter int ABITS    = DMEM_ABITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_valid,
  output logic                p0_ready,
  input  logic [REG_SIZE-1:0] p0_addr,
  input  logic                p0_wr,
  input  logic [1:0]          p0_size,
  input  logic                p0_signed,
  input  logic [REG_SIZE-1:0] p0_wdata,
  output logic                p0_rvalid,
  output logic [REG_SIZE-1:0] p0_rdata,
  output logic                p0_err,
  input  logic                p1_valid,
  output logic                p1_ready,
  input  logic [REG_SIZE-1:0] p1_addr,
  input  logic                p1_wr,
  input  logic [1:0]          p1_size,
  input  logic                p1_signed,
  input  logic [REG_SIZE-1:0] p1_wdata,
  output logic                p1_rvalid,
  output logic [REG_SIZE-1:0] p1_rdata,
  output logic                p1_err,
  output logic [REG_SIZE-1:0] daddr,
  output logic [1:0]          we,
  output logic [REG_SIZE-1:0] indata,
  input  logic [REG_SIZE-1:0] outdata,
  output logic                busy
);
  da_state_e           state_q;
  logic [7:0]          cnt_q;
  logic                port_q, wr_q, sgn_q;
  logic [1:0]          size_q, lo_q;
  logic [1:0]          we_q, rvalid_q, err_q;
  logic [REG_SIZE-1:0] daddr_q, indata_q, rdata_q;

  logic [1:0]          gnt;
  logic                idle, accept, sel, r_wr, r_sgn;
  logic [1:0]          r_size;
  logic [REG_SIZE-1:0] r_addr, r_wdata;

  function automatic logic is_illegal(input logic [1:0] size, input logic [REG_SIZE-1:0] addr);
    return (size == 2'd0) || (size == SZ_HALF && addr[0]) ||
           (size == SZ_WORD && addr[1:0] != 2'b00) || ((addr >> ABITS) != '0);
  endfunction

  function automatic logic [REG_SIZE-1:0] load_extend(input logic [REG_SIZE-1:0] w,
                                                      input logic [1:0] lo,
                                                      input logic [1:0] size,
                                                      input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign idle   = (state_q == DA_IDLE);
  assign accept = idle && (|gnt);
  assign sel    = gnt[1];

  rr_arb2 u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i ({p1_valid, p0_valid}),
    .upd_i (idle),
    .gnt_o (gnt)
  );

  assign r_addr  = sel ? p1_addr   : p0_addr;
  assign r_wr    = sel ? p1_wr     : p0_wr;
  assign r_size  = sel ? p1_size   : p0_size;
  assign r_sgn   = sel ? p1_signed : p0_signed;
  assign r_wdata = sel ? p1_wdata  : p0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DA_IDLE;
      we_q     <= '0;
      daddr_q  <= '0;
      indata_q <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      we_q     <= '0;
      case (state_q)
        DA_IDLE: begin
          if (accept) begin
            port_q <= sel;
            wr_q   <= r_wr;
            size_q <= r_size;
            sgn_q  <= r_sgn;
            lo_q   <= r_addr[1:0];
            if (is_illegal(r_size, r_addr)) begin
              state_q  <= DA_RESP;
              rvalid_q <= sel ? 2'b10 : 2'b01;
              err_q    <= sel ? 2'b10 : 2'b01;
              rdata_q  <= '0;
            end else begin
              // dmem inputs are registered here so they are stable for the whole ISSUE cycle.
              state_q <= DA_ISSUE;
              daddr_q <= r_addr;
              we_q    <= r_wr ? r_size : 2'b00;
              if (r_wr) indata_q <= lane_replicate(r_size, r_wdata);
            end
          end
        end
        DA_ISSUE: begin
          state_q <= DA_WAIT;
          cnt_q   <= 8'(DMEM_LAT - 1);
        end
        DA_WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q  <= DA_RESP;
            rvalid_q <= port_q ? 2'b10 : 2'b01;
            rdata_q  <= wr_q ? '0 : load_extend(outdata, lo_q, size_q, sgn_q);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= DA_IDLE;
      endcase
    end
  end

  assign p0_ready  = idle & gnt[0];
  assign p1_ready  = idle & gnt[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rvalid_q[0] ? rdata_q : '0;
  assign p1_rdata  = rvalid_q[1] ? rdata_q : '0;
  assign daddr     = daddr_q;
  assign we        = we_q;
  assign indata    = indata_q;
  assign busy      = !idle;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan steps plus randomized traffic against a byte-level reference.
module tb_dmem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p0_wr, p0_signed, p0_rvalid, p0_err;
  logic        p1_valid, p1_ready, p1_wr, p1_signed, p1_rvalid, p1_err;
  logic [1:0]  p0_size, p1_size, we;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic [31:0] daddr, indata, outdata;
  logic        busy;

  logic        pv[2], pwr[2], psg[2];
  logic [1:0]  psz[2];
  logic [31:0] pad[2], pwd[2];

  assign p0_valid = pv[0];  assign p0_wr = pwr[0]; assign p0_signed = psg[0];
  assign p0_size  = psz[0]; assign p0_addr = pad[0]; assign p0_wdata = pwd[0];
  assign p1_valid = pv[1];  assign p1_wr = pwr[1]; assign p1_signed = psg[1];
  assign p1_size  = psz[1]; assign p1_addr = pad[1]; assign p1_wdata = pwd[1];

  dmem_arbiter #(.DMEM_LAT(LAT), .ABITS(12)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wr(p0_wr),
    .p0_size(p0_size), .p0_signed(p0_signed), .p0_wdata(p0_wdata),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wr(p1_wr),
    .p1_size(p1_size), .p1_signed(p1_signed), .p1_wdata(p1_wdata),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .daddr(daddr), .we(we), .indata(indata), .outdata(outdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte-banked dmem with a two-stage read pipeline.
  logic [31:0] dm[1024];
  logic [31:0] rd1, rd2;
  bit          dm_init = 1'b0;
  always @(posedge clk) begin
    if (!dm_init) begin
      for (int i = 0; i < 1024; i++) dm[i] <= 32'h0;
      dm_init <= 1'b1;
    end else begin
      case (we)
        2'd1: dm[daddr[11:2]][{daddr[1:0], 3'b000} +: 8] <= indata[{daddr[1:0], 3'b000} +: 8];
        2'd2: dm[daddr[11:2]][{daddr[1], 4'b0000} +: 16] <= indata[{daddr[1], 4'b0000} +: 16];
        2'd3: dm[daddr[11:2]] <= indata;
        default: ;
      endcase
    end
    rd1 <= dm[daddr[11:2]];
    rd2 <= rd1;
  end
  assign outdata = rd2;

  int          checks = 0, failures = 0;
  int          rr_last;
  logic [31:0] ind_hold;
  logic [7:0]  rmem[4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p); return p == 0 ? p0_ready : p1_ready; endfunction
  function automatic logic rv(input int p);  return p == 0 ? p0_rvalid : p1_rvalid; endfunction
  function automatic logic er(input int p);  return p == 0 ? p0_err : p1_err; endfunction
  function automatic logic [31:0] rd(input int p); return p == 0 ? p0_rdata : p1_rdata; endfunction

  function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
    return sz == 0 || (sz == 2 && a % 2 != 0) || (sz == 3 && a % 4 != 0) || a >= 32'd4096;
  endfunction

  function automatic int nbytes(input logic [1:0] sz); return sz == 3 ? 4 : int'(sz); endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v = 0;
    int nb = nbytes(sz);
    for (int i = 0; i < nb; i++) v = v | (32'(rmem[a + i]) << (8 * i));
    if (nb < 4 && sg && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] w);
    for (int i = 0; i < nbytes(sz); i++) rmem[a + i] = 8'(w >> (8 * i));
  endtask

  function automatic logic [31:0] exp_repl(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 1) return 32'(w[7:0]) * 32'h0101_0101;
    if (sz == 2) return 32'(w[15:0]) * 32'h0001_0001;
    return w;
  endfunction

  task automatic set_req(input int p, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] w);
    pv[p] = 1'b1; pwr[p] = wr; psz[p] = sz; psg[p] = sg; pad[p] = a; pwd[p] = w;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a;
    a = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
    set_req(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  // Serve the request port p is presenting; it must be the arbitration winner.
  task automatic run_txn(input int p, input bit keep);
    bit          ill, got;
    int          n;
    logic [31:0] a, exp_rd;
    logic [1:0]  sz;
    #1;
    a = pad[p]; sz = psz[p];
    ill = is_illegal(sz, a);
    exp_rd = (pwr[p] || ill) ? 32'h0 : ref_load(a, sz, psg[p]);
    n = 0;
    while (!rdy(p) && n < 20) begin @(negedge clk); #1; n++; end
    chk("ready_winner", 32'(rdy(p)), 32'd1);
    chk("ready_loser", 32'(rdy(1 - p)), 32'd0);
    rr_last = p;
    @(negedge clk); #1;
    if (!keep) pv[p] = 1'b0;
    if (pwr[p] && !ill) ref_store(a, sz, pwd[p]);
    got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (c == 1 && !ill) begin
        chk("issue_we", 32'(we), pwr[p] ? 32'(sz) : 32'd0);
        chk("issue_daddr", daddr, a);
        if (pwr[p]) ind_hold = exp_repl(sz, pwd[p]);
        chk("issue_indata", indata, ind_hold);
      end else begin
        chk("we_zero", 32'(we), 32'd0);
      end
      chk("busy_ready", {30'b0, p1_ready, p0_ready}, 32'd0);
      chk("other_rvalid", 32'(rv(1 - p)), 32'd0);
      if (rv(p)) begin
        got = 1;
        chk("latency", 32'(c), ill ? 32'd1 : 32'(LAT + 2));
        chk("rdata", rd(p), exp_rd);
        chk("err", 32'(er(p)), 32'(ill));
      end else begin
        chk("rdata_quiet", rd(p), 32'd0);
        chk("err_quiet", 32'(er(p)), 32'd0);
        @(negedge clk); #1;
      end
    end
    chk("rvalid_seen", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, win;
    for (int i = 0; i < 4096; i++) rmem[i] = 8'h0;
    for (int q = 0; q < 2; q++) begin
      pv[q] = 0; pwr[q] = 0; psz[q] = 0; psg[q] = 0; pad[q] = 0; pwd[q] = 0;
    end
    rst = 1'b1; rr_last = 1; ind_hold = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_indata", indata, 0);
    chk("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 0);
    chk("rst_err", {30'b0, p1_err, p0_err}, 0);
    chk("rst_rdata", p0_rdata | p1_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then load.
    set_req(0, 1, 3, 0, 32'h010, 32'hDEAD_BEEF); run_txn(0, 0);
    set_req(0, 0, 3, 0, 32'h010, 32'h0);         run_txn(0, 0);
    // Byte store then signed and unsigned byte loads.
    set_req(0, 1, 1, 0, 32'h013, 32'h0000_0080); run_txn(0, 0);
    set_req(0, 0, 1, 1, 32'h013, 32'h0);         run_txn(0, 0);
    set_req(1, 0, 1, 0, 32'h013, 32'h0);         run_txn(1, 0);
    set_req(1, 0, 2, 1, 32'h012, 32'h0);         run_txn(1, 0);
    // Illegal requests.
    set_req(0, 0, 2, 0, 32'h011, 32'h0);         run_txn(0, 0);
    set_req(1, 1, 3, 0, 32'h012, 32'h1234_5678); run_txn(1, 0);
    set_req(0, 1, 0, 0, 32'h014, 32'h5555_5555); run_txn(0, 0);
    set_req(1, 0, 3, 0, 32'h1000, 32'h0);        run_txn(1, 0);

    // Both ports continuously valid with loads: grants must alternate.
    set_req(0, 0, 3, 0, 32'h010, 32'h0);
    set_req(1, 0, 1, 1, 32'h013, 32'h0);
    for (int k = 0; k < 6; k++) begin
      win = 1 - rr_last;
      run_txn(win, 1);
      set_req(win, 0, 3, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), 32'h0);
    end
    pv[0] = 0; pv[1] = 0;
    @(negedge clk);

    // Randomized traffic with frequent ties.
    for (int it = 0; it < 60; it++) begin
      for (int q = 0; q < 2; q++)
        if (!pv[q] && ($urandom_range(0, 1) == 1 || (q == 1 && !pv[0]))) rand_req(q);
      win = (pv[0] && pv[1]) ? 1 - rr_last : (pv[0] ? 0 : 1);
      run_txn(win, 0);
    end
    if (pv[0]) run_txn(0, 0);
    if (pv[1]) run_txn(1, 0);

    // Reset during the WAIT of a store.
    set_req(0, 1, 3, 0, 32'h020, 32'h1234_5678);
    #1;
    n = 0;
    while (!p0_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("rstop_ready", 32'(p0_ready), 1);
    @(negedge clk); #1;
    pv[0] = 0;
    ref_store(32'h020, 3, 32'h1234_5678);
    @(negedge clk); #1;
    chk("rstop_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstop_busy", 32'(busy), 0);
    chk("rstop_we", 32'(we), 0);
    chk("rstop_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 0);
    rst = 1'b0; rr_last = 1; ind_hold = 0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("post_rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 0);
      chk("post_rst_we", 32'(we), 0);
    end
    set_req(0, 0, 3, 0, 32'h020, 32'h0);
    set_req(1, 0, 1, 1, 32'h013, 32'h0);
    run_txn(0, 0);
    run_txn(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-banked `dmem` data memory. It accepts load/store requests from two masters over valid/ready handshakes: port 0 is the CPU memory stage, port 1 is the loader/DMA. It grants one request at a time round-robin and drives `dmem`'s `daddr`/`we`/`indata` with correct byte-lane replication. It waits out the memory's fixed read latency, then returns lane-extracted, sign- or zero-extended load data, or an error for illegal accesses.

## Interface
Parameters:
- `DMEM_LAT`, default 2: cycles from the `dmem` input sample edge to valid `outdata`.
- `ABITS`, default 12: byte-address width backed by `dmem` (4 KiB).

Ports. Clock and reset are fixed: one clock, synchronous active-high reset.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pN_valid`  in  1  request valid, N = 0, 1.
- `pN_ready`  out  1  request accepted this cycle when `pN_valid & pN_ready`.
- `pN_addr`  in  `REG_SIZE`  byte address.
- `pN_wr`  in  1  1 = store, 0 = load.
- `pN_size`  in  2  1 = byte, 2 = half, 3 = word, 0 = illegal (same encoding as `dmem` `we`).
- `pN_signed`  in  1  sign-extend load data.
- `pN_wdata`  in  `REG_SIZE`  store data, right-aligned.
- `pN_rvalid`  out  1  one-cycle response strobe (load data or store ack).
- `pN_rdata`  out  `REG_SIZE`  extended load data; 0 for stores and errors.
- `pN_err`  out  1  qualifies `pN_rvalid`; request was illegal and was not performed.
- `daddr`  out  `REG_SIZE`  to `dmem`.
- `we`  out  2  to `dmem`; nonzero only in ISSUE.
- `indata`  out  `REG_SIZE`  to `dmem`, lane-replicated.
- `outdata`  in  `REG_SIZE`  from `dmem`.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `pN_ready` is combinational: 1 only for the arbitration winner among asserted valids. On accept, latch port id, addr, wr, size, signed, wdata.
  - Legal request goes to ISSUE.
  - Illegal request goes directly to RESP with err = 1.
- Illegal conditions:
  - size == 0;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:ABITS] != 0.
- ISSUE (1 cycle): `daddr` = latched addr; `we` = size if store, else 0. Store data on `indata`:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
  - Loads leave `indata` unchanged. Go to WAIT.
- WAIT: hold for exactly `DMEM_LAT` cycles on a down-counter, with `we` = 0. Loads capture `outdata` on the last WAIT cycle. Go to RESP.
- RESP (1 cycle): assert `rvalid` on the latched port only.
  - Byte load: lane = addr[1:0].
  - Half load: lane = addr[1].
  - Extension: sign if `signed`, else zero.
  - Word loads pass through.
  - Stores return rdata = 0.
  - Go to IDLE.
- `daddr`/`indata` hold their last values outside ISSUE; `we` is 0 in every state except ISSUE.
- Arbitration: round-robin pointer to the last granted port. With both valids asserted, the other port wins. A single valid always wins. The pointer updates only on accept, including error accepts.
- `pN_rdata`/`pN_err` are valid only while `pN_rvalid`; they are 0 otherwise.

## Timing
- Accept at cycle T (handshake edge ends T).
- Legal access: ISSUE at T+1, WAIT T+2..T+1+DMEM_LAT, RESP at T+2+DMEM_LAT. The default gives rvalid at T+4.
- Error: RESP at T+1, no `dmem` access.
- Throughput: one legal access per DMEM_LAT+3 cycles. The next accept can occur in the IDLE cycle following RESP; there is no same-cycle accept in RESP.
- Reset values: all outputs 0, state IDLE, RR pointer = port 1 so port 0 wins the first tie.
- Reset mid-operation: next cycle IDLE with `we` = 0. The in-flight request is dropped with no rvalid, and a partial write is not retried.
- A requester must hold valid and payload stable until ready. A withdrawn valid is permitted and simply loses arbitration.

## Structure
- `params.v` gains:
  - size codes `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - `DMEM_ABITS`;
  - FSM state encodings `DA_IDLE`, `DA_ISSUE`, `DA_WAIT`, `DA_RESP` (2-bit).
- Sub-module `rr_arb2`: combinational two-request round-robin grant plus registered last-grant pointer with an update enable. It is reusable for the instruction-memory side.
- The load extract/extend function stays local to `dmem_arbiter`.

## Test plan
- Port 0 stores word 0xDEADBEEF at 0x010, then loads word 0x010 → `we` = 3 for one cycle, `indata` = 0xDEADBEEF. Load rvalid 4 cycles after accept with rdata 0xDEADBEEF, err 0.
- Byte store 0x80 at 0x013, then loads:
  - signed byte 0x013 → 0xFFFFFF80;
  - unsigned → 0x00000080.
  - The store drove `indata` = 0x80808080 with `we` = 1.
- Both ports valid continuously with loads → grants alternate 0,1,0,1. No port gets two consecutive grants, and each rvalid appears only on its owner port.
- Half load at 0x011, word store at 0x012, size 0, addr 0x1000 → each gives rvalid + err at T+1 with rdata 0. `we` stays 0 throughout.
- Assert `rst` during WAIT of a store → next cycle busy = 0 and `we` = 0, no rvalid. The first post-reset tie is granted to port 0.
